// File: rtl/jrb8_io_pkg.sv
// Shared widths, default timing constants and the byte type for the
// jrb8 input-conditioning path.
package jrb8_io_pkg;

    localparam int IO_WIDTH             = 8;
    localparam int DEF_SYNC_STAGES      = 2;
    localparam logic [23:0] DEF_TICK_DIV = 24'd10_000;
    localparam int DEF_STABLE_TICKS     = 4;

    typedef logic [IO_WIDTH-1:0] io_byte_t;

endpackage

// File: rtl/input_conditioner_debounce_bit.sv
// One switch bit: metastability synchroniser, tick-driven stability counter,
// debounced level and registered edge pulses.
module debounce_bit
    import jrb8_io_pkg::*;
#(
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter int STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic tick,
    input  logic raw,
    output logic clean,
    output logic rise,
    output logic fall,
    output logic accept
);

    localparam int CW = $clog2(STABLE_TICKS + 1);

    logic [SYNC_STAGES-1:0] sync;
    logic [CW-1:0]          cnt;
    logic                   sync_out;
    logic                   differ;

    assign sync_out = sync[SYNC_STAGES-1];
    assign differ   = (sync_out != clean);
    // Combinational so the top can register its changed flag alongside rise/fall.
    assign accept   = en && tick && differ && ((cnt + CW'(1)) == CW'(STABLE_TICKS));

    // Synchroniser chain, free-running regardless of enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], raw};
        end
    end

    // Stability counter, accepted level and one-cycle edge pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            clean <= 1'b0;
            rise  <= 1'b0;
            fall  <= 1'b0;
        end else begin
            rise <= 1'b0;
            fall <= 1'b0;
            if (en && tick) begin
                if (!differ) begin
                    cnt <= '0;
                end else if (accept) begin
                    clean <= sync_out;
                    cnt   <= '0;
                    rise  <= sync_out;
                    fall  <= !sync_out;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end else begin
                cnt <= cnt;
            end
        end
    end

endmodule

// File: rtl/input_conditioner.sv
// Debounced 8-bit switch front end with shared sample-tick prescaler.
// Define JRB8_INPUT_EVENT_EN to build the evt_* capture/handshake register.
module input_conditioner
    import jrb8_io_pkg::*;
#(
    parameter int          SYNC_STAGES  = DEF_SYNC_STAGES,
    parameter logic [23:0] TICK_DIV     = DEF_TICK_DIV,
    parameter int          STABLE_TICKS = DEF_STABLE_TICKS
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     en,
    input  io_byte_t raw_in,
    output io_byte_t clean,
    output io_byte_t rise,
    output io_byte_t fall,
    output logic     changed,
    output logic     evt_valid,
    output io_byte_t evt_data,
    output logic     evt_overrun,
    input  logic     evt_ack
);

    logic [23:0] pre_count;
    logic        tick;
    io_byte_t    accept;

    assign tick = en && (pre_count == (TICK_DIV - 24'd1));

    // Sample-tick prescaler; parked at zero while disabled so resume is deterministic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_count <= 24'd0;
        end else if (!en || tick) begin
            pre_count <= 24'd0;
        end else begin
            pre_count <= pre_count + 24'd1;
        end
    end

    for (genvar i = 0; i < IO_WIDTH; i++) begin : g_bit
        debounce_bit #(
            .SYNC_STAGES (SYNC_STAGES),
            .STABLE_TICKS(STABLE_TICKS)
        ) u_bit (
            .clk   (clk),
            .rst   (rst),
            .en    (en),
            .tick  (tick),
            .raw   (raw_in[i]),
            .clean (clean[i]),
            .rise  (rise[i]),
            .fall  (fall[i]),
            .accept(accept[i])
        );
    end

    // Change flag, registered in the same cycle as the rise/fall pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            changed <= 1'b0;
        end else begin
            changed <= |accept;
        end
    end

`ifdef JRB8_INPUT_EVENT_EN
    // Event capture: newest clean byte wins, overrun flags a change lost before ack.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            evt_valid   <= 1'b0;
            evt_data    <= '0;
            evt_overrun <= 1'b0;
        end else if (changed) begin
            evt_data  <= clean;
            evt_valid <= 1'b1;
            if (evt_valid) begin
                evt_overrun <= !evt_ack;
            end else begin
                evt_overrun <= evt_overrun;
            end
        end else if (evt_ack && evt_valid) begin
            evt_valid   <= 1'b0;
            evt_overrun <= 1'b0;
        end else begin
            evt_valid   <= evt_valid;
            evt_overrun <= evt_overrun;
        end
    end
`else
    logic unused_evt_ack;
    assign unused_evt_ack = evt_ack;
    assign evt_valid      = 1'b0;
    assign evt_data       = '0;
    assign evt_overrun    = 1'b0;
`endif

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner: vector table on a TICK_DIV=1 instance,
// a TICK_DIV=4 instance for tick alignment, plus event and reset sequences.
module tb_input_conditioner;
    import jrb8_io_pkg::*;

`ifdef JRB8_INPUT_EVENT_EN
    localparam bit EVT_ON = 1'b1;
`else
    localparam bit EVT_ON = 1'b0;
`endif

    logic     clk = 1'b0;
    logic     rst, en, evt_ack, en4, evt_ack4;
    io_byte_t raw_in, clean, rise, fall, evt_data;
    io_byte_t raw4, clean4, rise4, fall4, evt_data4;
    logic     changed, evt_valid, evt_overrun;
    logic     changed4, evt_valid4, evt_overrun4;
    int       checks   = 0;
    int       failures = 0;

    always #5 clk = ~clk;

    input_conditioner #(.TICK_DIV(24'd1)) dut (
        .clk(clk), .rst(rst), .en(en), .raw_in(raw_in),
        .clean(clean), .rise(rise), .fall(fall), .changed(changed),
        .evt_valid(evt_valid), .evt_data(evt_data), .evt_overrun(evt_overrun),
        .evt_ack(evt_ack)
    );

    input_conditioner #(.TICK_DIV(24'd4)) dut4 (
        .clk(clk), .rst(rst), .en(en4), .raw_in(raw4),
        .clean(clean4), .rise(rise4), .fall(fall4), .changed(changed4),
        .evt_valid(evt_valid4), .evt_data(evt_data4), .evt_overrun(evt_overrun4),
        .evt_ack(evt_ack4)
    );

    typedef struct {
        logic [7:0] raw;
        logic       en;
        logic [7:0] clean;
        logic [7:0] rise;
        logic [7:0] fall;
        logic       changed;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // n rows of one input setting; the new level appears at row 'at' (-1: never).
    task automatic add_run(input logic [7:0] r, input logic e, input int n,
                           input logic [7:0] c_before, input logic [7:0] c_after,
                           input logic [7:0] ri, input logic [7:0] fa, input int at);
        vec_t v;
        for (int k = 0; k < n; k++) begin
            v.raw     = r;
            v.en      = e;
            v.clean   = (at >= 0 && k >= at) ? c_after : c_before;
            v.rise    = (k == at) ? ri : 8'h00;
            v.fall    = (k == at) ? fa : 8'h00;
            v.changed = (k == at);
            vecs.push_back(v);
        end
    endtask

    task automatic change_to(input logic [7:0] v, input logic ack_on_change);
        int n;
        raw_in = v;
        n = 0;
        do begin
            step();
            n++;
        end while (!changed && n < 30);
        chk("change_seen", {31'd0, changed}, 32'd1);
        chk("change_clean", clean, v);
        evt_ack = ack_on_change;
        step();
        evt_ack = 1'b0;
    endtask

    task automatic chk_evt(input string name, input logic v, input logic [7:0] d, input logic o);
        if (EVT_ON) begin
            chk(name, {evt_valid, evt_data, evt_overrun}, {v, d, o});
        end else begin
            chk(name, {evt_valid, evt_data, evt_overrun}, 10'd0);
        end
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first4, rise4_cnt, fall4_seen;

        rst = 1'b1; en = 1'b1; evt_ack = 1'b0; raw_in = 8'h00;
        en4 = 1'b1; evt_ack4 = 1'b0; raw4 = 8'h00;
        step();
        step();
        chk("reset_dut", {clean, rise, fall, changed, evt_valid, evt_data, evt_overrun}, 35'd0);
        chk("reset_dut4", {clean4, rise4, fall4, changed4, evt_valid4, evt_data4, evt_overrun4}, 35'd0);
        rst = 1'b0;

        // TICK_DIV=4: ticks at edges 3,7,11,15 -> clean at edge 15
        raw4 = 8'h01;
        first4 = -1; rise4_cnt = 0; fall4_seen = 0;
        for (int r = 0; r < 22; r++) begin
            step();
            if (clean4 != 8'h00 && first4 < 0) first4 = r;
            if (rise4 == 8'h01) rise4_cnt++;
            if (fall4 != 8'h00) fall4_seen++;
        end
        chk("tick4_not_early", {31'd0, (first4 >= 14)}, 32'd1);
        chk("tick4_edge", first4, 32'd15);
        chk("tick4_rise_once", rise4_cnt, 32'd1);
        chk("tick4_no_fall", fall4_seen, 32'd0);

        add_run(8'h01, 1'b1, 3,  8'h00, 8'h00, 8'h00, 8'h00, -1);
        add_run(8'h00, 1'b1, 7,  8'h00, 8'h00, 8'h00, 8'h00, -1);
        add_run(8'h81, 1'b1, 8,  8'h00, 8'h81, 8'h81, 8'h00, 5);
        add_run(8'h80, 1'b1, 8,  8'h81, 8'h80, 8'h00, 8'h01, 5);
        add_run(8'h7F, 1'b1, 8,  8'h80, 8'h7F, 8'h7F, 8'h80, 5);
        add_run(8'h00, 1'b1, 8,  8'h7F, 8'h00, 8'h00, 8'h7F, 5);
        add_run(8'hF0, 1'b0, 20, 8'h00, 8'h00, 8'h00, 8'h00, -1);
        add_run(8'hF0, 1'b1, 5,  8'h00, 8'hF0, 8'hF0, 8'h00, 3);
        add_run(8'h0F, 1'b1, 3,  8'hF0, 8'hF0, 8'h00, 8'h00, -1);
        add_run(8'h0F, 1'b0, 10, 8'hF0, 8'hF0, 8'h00, 8'h00, -1);
        add_run(8'h0F, 1'b1, 4,  8'hF0, 8'h0F, 8'h0F, 8'hF0, 2);

        foreach (vecs[i]) begin
            raw_in = vecs[i].raw;
            en     = vecs[i].en;
            step();
            if ({clean, rise, fall, changed} !==
                {vecs[i].clean, vecs[i].rise, vecs[i].fall, vecs[i].changed}) begin
                $display("FAIL vec[%0d]: got clean=%h rise=%h fall=%h changed=%b expected clean=%h rise=%h fall=%h changed=%b",
                         i, clean, rise, fall, changed,
                         vecs[i].clean, vecs[i].rise, vecs[i].fall, vecs[i].changed);
                failures++;
            end
            checks++;
            if (!EVT_ON) chk("evt_tied_off", {evt_valid, evt_data, evt_overrun}, 10'd0);
        end

        // Event capture / overrun / ack sequence
        en = 1'b1;
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk_evt("evt_cleared0", 1'b0, evt_data, 1'b0);
        change_to(8'h01, 1'b0);
        chk_evt("evt_first", 1'b1, 8'h01, 1'b0);
        change_to(8'h03, 1'b0);
        chk_evt("evt_overrun", 1'b1, 8'h03, 1'b1);
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk_evt("evt_acked", 1'b0, 8'h03, 1'b0);
        evt_ack = 1'b1;
        step();
        evt_ack = 1'b0;
        chk_evt("evt_idle_ack", 1'b0, 8'h03, 1'b0);
        change_to(8'h0F, 1'b0);
        chk_evt("evt_new", 1'b1, 8'h0F, 1'b0);
        change_to(8'h1F, 1'b0);
        chk_evt("evt_overrun2", 1'b1, 8'h1F, 1'b1);
        change_to(8'h07, 1'b1);
        chk_evt("evt_ack_coincident", 1'b1, 8'h07, 1'b0);

        // Reset in the middle of a debounce run
        raw_in = 8'hFF;
        step();
        step();
        step();
        rst = 1'b1;
        #1;
        chk("rst_async", {clean, rise, fall, changed, evt_valid, evt_data, evt_overrun}, 35'd0);
        step();
        step();
        rst = 1'b0;
        for (int r = 0; r < 6; r++) begin
            step();
            if (r == 4) chk("post_rst_wait", {clean, rise}, 16'h0000);
            if (r == 5) chk("post_rst_rise", {clean, rise, changed}, {8'hFF, 8'hFF, 1'b1});
        end
        step();
        chk("post_rst_pulse_end", {clean, rise, changed}, {8'hFF, 8'h00, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
